// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and framebuffer geometry shared by the VGA blocks
package vga_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int PIX_W = 4;
  localparam int WORDS_PER_LINE = H_VISIBLE / 4;
  localparam int ADDR_W = 17;
endpackage

// File: rtl/vga_fetch_sched.sv
// vga_fetch_sched: display fetch slot and word address, two pixel clocks ahead of h_cnt/v_cnt
// Ports: h_cnt/v_cnt in from the timing generator; disp_slot and disp_addr out.
module vga_fetch_sched
  import vga_pkg::*;
(
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  output logic              disp_slot,
  output logic [ADDR_W-1:0] disp_addr
);
  logic       wrap;
  logic [9:0] fh;
  logic [9:0] fv;
  always_comb begin
    wrap = h_cnt >= 10'(H_TOTAL - 2);
    fh = wrap ? h_cnt - 10'(H_TOTAL - 2) : h_cnt + 10'd2;
    fv = !wrap ? v_cnt : (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
    // Out-of-range counts never produce a slot, whatever fh/fv happen to wrap to.
    disp_slot = (h_cnt < 10'(H_TOTAL)) && (v_cnt < 10'(V_TOTAL)) && (fh[1:0] == 2'd0)
              && (fh < 10'(H_VISIBLE)) && (fv < 10'(V_VISIBLE));
    disp_addr = ADDR_W'(fv) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(fh[9:2]);
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one framebuffer RAM between display scan-out (fixed priority) and a host port
// Ports: clk_25mhz/reset; h_cnt/v_cnt/video_on from timing; pixel_out to palette;
// host_* valid/ready request with registered read response; mem_* to the single-port RAM.
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic              clk_25mhz,
  input  logic              reset,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              video_on,
  output logic [PIX_W-1:0]  pixel_out,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  input  logic [3:0]        host_be,
  output logic              host_rvalid,
  output logic [15:0]       host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [15:0]       mem_rdata
);
  logic              disp_slot;
  logic [ADDR_W-1:0] disp_addr;
  logic              slot;
  logic              accept;
  logic              slot_q;
  logic              rvalid_q;
  logic [15:0]       word_q;
  vga_fetch_sched u_sched (
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .disp_slot (disp_slot),
    .disp_addr (disp_addr)
  );
  assign slot = disp_slot & ~reset;
  assign host_ready = ~disp_slot & ~reset;
  assign accept = host_valid & host_ready;
  assign mem_en = slot | accept;
  assign mem_we = accept & host_we;
  // Idle address follows the display schedule so it is never X after reset.
  assign mem_addr = accept ? host_addr : disp_addr;
  assign mem_wdata = accept ? host_wdata : 16'h0;
  assign mem_be = accept ? (host_we ? host_be : 4'hF) : slot ? 4'hF : 4'h0;
  // Gating with reset kills a response for a read accepted just before reset.
  assign host_rvalid = rvalid_q & ~reset;
  assign host_rdata = mem_rdata;
  assign pixel_out = (video_on & ~reset) ? word_q[{h_cnt[1:0], 2'b00} +: PIX_W] : '0;
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      slot_q <= 1'b0;
      rvalid_q <= 1'b0;
      word_q <= 16'h0;
    end else begin
      slot_q <= disp_slot;
      rvalid_q <= accept & ~host_we;
      if (slot_q) word_q <= mem_rdata;
    end
  end
endmodule
